// File: rtl/mem_access_unit_if.sv
// rtl/mem_access_unit_if.sv - request/response and async_mem bus bundle for mem_access_unit
interface mem_access_unit_if #(
  parameter int AW = 32
);
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;

  logic          rsp_valid;
  logic          rsp_ready;
  logic [31:0]   rsp_rdata;
  logic          rsp_err;

  logic          mem_read;
  logic          mem_write;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_write_data;
  logic [31:0]   mem_read_data;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready, mem_read_data,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
           mem_read, mem_write, mem_addr, mem_write_data
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready, mem_read_data,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
           mem_read, mem_write, mem_addr, mem_write_data
  );
endinterface

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - async_mem bus initiator with fixed read wait and valid/ready response
module mem_access_unit #(
  parameter int WAIT_CYCLES = 3,
  parameter int AW          = 32
) (
  input  logic              clk,
  input  logic              reset,
  mem_access_unit_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RD_WAIT, WR, RESP} state_t;

  localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

  state_t        state;
  state_t        state_nxt;
  logic [3:0]    cnt;
  logic [AW-1:0] addr_q;
  logic [31:0]   wdata_q;
  logic [31:0]   rdata_q;
  logic          err_q;
  logic          misaligned;

  logic req_ready_c;
  logic rsp_valid_c;
  logic mem_read_c;
  logic mem_write_c;

  assign misaligned = |bus.req_addr[1:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Strobes decode straight from state so an async reset drops them at once.
  always_comb begin
    state_nxt   = state;
    req_ready_c = 1'b0;
    rsp_valid_c = 1'b0;
    mem_read_c  = 1'b0;
    mem_write_c = 1'b0;
    case (state)
      IDLE: begin
        req_ready_c = 1'b1;
        if (bus.req_valid) begin
          if (misaligned)         state_nxt = RESP;
          else if (bus.req_write) state_nxt = WR;
          else                    state_nxt = RD_WAIT;
        end
      end
      RD_WAIT: begin
        mem_read_c = 1'b1;
        if (cnt == LAST_CNT) state_nxt = RESP;
      end
      WR: begin
        mem_write_c = 1'b1;
        state_nxt   = RESP;
      end
      RESP: begin
        rsp_valid_c = 1'b1;
        if (bus.rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
            cnt     <= '0;
            rdata_q <= '0;
            err_q   <= misaligned;
          end
        end
        RD_WAIT: begin
          cnt <= cnt + 4'd1;
          // Last wait cycle: the combinational read path has settled by now.
          if (cnt == LAST_CNT) rdata_q <= bus.mem_read_data;
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready      = req_ready_c;
  assign bus.rsp_valid      = rsp_valid_c;
  assign bus.rsp_rdata      = rdata_q;
  assign bus.rsp_err        = err_q;
  assign bus.mem_read       = mem_read_c;
  assign bus.mem_write      = mem_write_c;
  assign bus.mem_addr       = addr_q;
  assign bus.mem_write_data = wdata_q;

endmodule
